calendar_counter: RTL and testbench
===================================

CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 The block SHALL have parameter YEAR_W, default 12, giving the year register width in bits (legal range 11..16).
REQ-002 The block SHALL have parameter RESET_YEAR, default 2000, giving the year value loaded at reset; it SHALL fit in YEAR_W bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: advance the date by one day.
REQ-006 The block SHALL have port load, input, 1 bit: request to load load_day, load_month and load_year.
REQ-007 The block SHALL have port load_day, input, 5 bits: day of month, 1..31.
REQ-008 The block SHALL have port load_month, input, 4 bits: month, 1..12.
REQ-009 The block SHALL have port load_year, input, YEAR_W bits: year.
REQ-010 The block SHALL have port day, output, 5 bits: current day of month.
REQ-011 The block SHALL have port month, output, 4 bits: current month.
REQ-012 The block SHALL have port year, output, YEAR_W bits: current year.
REQ-013 The block SHALL have port day_of_yr, output, 9 bits: ordinal day, 1..366.
REQ-014 The block SHALL have port leap, output, 1 bit: the current year is a Gregorian leap year.
REQ-015 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-016 The block SHALL have port year_wrap, output, 1 bit: one-cycle pulse when the year rolls from 2^YEAR_W-1 to 0.

Function
REQ-017 leap SHALL be 1 iff (year mod 4 = 0 and year mod 100 != 0) or year mod 400 = 0, using the full Gregorian rule.
REQ-018 Month length SHALL be 31/28/31/30/31/30/31/31/30/31/30/31, with February taking 29 when the year is a leap year.
REQ-019 A tick with load=0 SHALL increment day in the next cycle; at month end it SHALL set day=1 and increment month; after December 31 it SHALL set day=1, month=1 and year+1.
REQ-020 On each accepted tick, day_of_yr SHALL increment by 1, or reset to 1 on January 1; it SHALL be registered alongside the date with no extra latency.
REQ-021 A load SHALL be accepted iff 1<=load_month<=12 and 1<=load_day<=month length for load_month in load_year (leap evaluated on load_year).
REQ-022 An accepted load SHALL update day, month, year and day_of_yr in the next cycle, where day_of_yr = cumulative days before the month + load_day + 1 if month>2 and load_year is leap.
REQ-023 A rejected load SHALL leave all state unchanged and assert load_err for exactly the next cycle.
REQ-024 When load and tick are both 1, load SHALL take priority and the tick SHALL be discarded, including when the load is rejected.
REQ-025 Year increment from 2^YEAR_W-1 SHALL wrap to 0 and assert year_wrap for one cycle; year 0 SHALL be treated as leap.
REQ-026 day, month, year, day_of_yr, load_err and year_wrap SHALL all be registered outputs; leap SHALL be derived from the registered year.

Reset
REQ-027 While rst=1, the outputs SHALL be day=1, month=1, year=RESET_YEAR, day_of_yr=1, load_err=0, year_wrap=0, asynchronously and mid-operation included.
REQ-028 The first tick or load SHALL be honoured on the first rising clk edge after rst deasserts.

Structure
REQ-029 A shared package calendar_pkg SHALL hold the month-length and cumulative-days-before-month constant tables and the month enumeration.
REQ-030 Leap evaluation SHALL live in one combinational sub-module leap_year_det, parametrised by YEAR_W, instanced twice: once for the current year and once for load_year.

Verification
REQ-031 Reset with RESET_YEAR=2000 -> 1/1/2000, day_of_yr=1, leap=1.
REQ-032 Load 28/2/1900, then tick -> 1/3/1900, day_of_yr=60, leap=0.
REQ-033 Load 28/2/2000, tick -> 29/2/2000 with day_of_yr=60; tick again -> 1/3/2000 with day_of_yr=61.
REQ-034 Load 31/12/2023 (day_of_yr=365), tick -> 1/1/2024, day_of_yr=1, leap=1.
REQ-035 Load 30/2/2024 with tick=1 in the same cycle -> load_err pulses once; state and day_of_yr unchanged; tick discarded.
REQ-036 YEAR_W=12: load 31/12/4095, tick -> 1/1/0, year_wrap pulses once, leap=1.

Source files
------------

// File: rtl/calendar_pkg.sv
// -----------------------------------------------------------------------------
// calendar_pkg
// Shared calendar constants for the calendar counter:
//   - month enumeration (JAN = 1 .. DEC = 12, 0 and 13..15 are illegal)
//   - month-length table for a non-leap year
//   - cumulative days before each month for a non-leap year
//   - helper functions that apply the February leap adjustment
// Tables are indexed directly by the 4-bit month code. Illegal codes map to 0,
// so a stray index can never produce a plausible-looking length.
// -----------------------------------------------------------------------------
package calendar_pkg;

    typedef enum logic [3:0] {
        MON_NONE = 4'd0,
        JAN      = 4'd1,
        FEB      = 4'd2,
        MAR      = 4'd3,
        APR      = 4'd4,
        MAY      = 4'd5,
        JUN      = 4'd6,
        JUL      = 4'd7,
        AUG      = 4'd8,
        SEP      = 4'd9,
        OCT      = 4'd10,
        NOV      = 4'd11,
        DEC      = 4'd12
    } month_e;

    // Days per month in a common year; February is patched for leap years.
    localparam logic [4:0] MONTH_DAYS [0:15] = '{
        5'd0,
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
        5'd0,  5'd0,  5'd0
    };

    // Days elapsed before the first of each month in a common year.
    localparam logic [8:0] CUM_DAYS [0:15] = '{
        9'd0,
        9'd0,   9'd31,  9'd59,  9'd90,  9'd120, 9'd151,
        9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334,
        9'd0,   9'd0,   9'd0
    };

    // Length of a month, including the leap-year February.
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic       is_leap);
        logic [4:0] len;
        if ((month == FEB) && is_leap) begin
            len = 5'd29;
        end else begin
            len = MONTH_DAYS[month];
        end
        return len;
    endfunction

    // Ordinal day of year for a (legal) day/month pair.
    function automatic logic [8:0] ordinal_day(input logic [4:0] day,
                                               input logic [3:0] month,
                                               input logic       is_leap);
        logic [8:0] extra;
        if (is_leap && (month > FEB)) begin
            extra = 9'd1;
        end else begin
            extra = 9'd0;
        end
        return CUM_DAYS[month] + 9'(day) + extra;
    endfunction

endpackage

// File: rtl/leap_year_det.sv
// -----------------------------------------------------------------------------
// leap_year_det
// Combinational Gregorian leap-year detector.
//   year : input,  YEAR_W bits - year to classify
//   leap : output, 1 bit       - 1 iff (year%4==0 && year%100!=0) || year%400==0
// Year 0 is divisible by 400 and therefore classified as leap.
// -----------------------------------------------------------------------------
module leap_year_det #(
    parameter int YEAR_W = 12
) (
    input  logic [YEAR_W-1:0] year,
    output logic              leap
);

    logic [15:0] year_ext_s;
    logic        div4_s;
    logic        div100_s;
    logic        div400_s;

    // Widen to a fixed 16 bits so the modulo constants have one width for all YEAR_W.
    always_comb begin
        year_ext_s = 16'(year);
        div4_s     = (year_ext_s[1:0] == 2'b00);
        div100_s   = ((year_ext_s % 16'd100) == 16'd0);
        div400_s   = ((year_ext_s % 16'd400) == 16'd0);
        leap       = (div4_s && !div100_s) || div400_s;
    end

endmodule

// File: rtl/calendar_counter.sv
// -----------------------------------------------------------------------------
// calendar_counter
// Day/month/year counter with ordinal day, leap flag and validated load.
//   clk        : input  - single clock, rising edge
//   rst        : input  - asynchronous active-high reset (1/1/RESET_YEAR)
//   tick       : input  - advance date by one day
//   load       : input  - load load_day/load_month/load_year (beats tick)
//   load_day   : input  [4:0]        - day 1..31
//   load_month : input  [3:0]        - month 1..12
//   load_year  : input  [YEAR_W-1:0] - year
//   day        : output [4:0]        - current day (registered)
//   month      : output [3:0]        - current month (registered)
//   year       : output [YEAR_W-1:0] - current year (registered)
//   day_of_yr  : output [8:0]        - ordinal day 1..366 (registered)
//   leap       : output              - current year is leap (from registered year)
//   load_err   : output              - one-cycle pulse on a rejected load
//   year_wrap  : output              - one-cycle pulse on year 2^YEAR_W-1 -> 0
// -----------------------------------------------------------------------------
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [8:0]        day_of_yr,
    output logic              leap,
    output logic              load_err,
    output logic              year_wrap
);

    logic [4:0]        day_r;
    logic [3:0]        month_r;
    logic [YEAR_W-1:0] year_r;
    logic [8:0]        doy_r;
    logic              load_err_r;
    logic              year_wrap_r;

    logic              leap_cur_s;
    logic              leap_load_s;
    logic [4:0]        cur_len_s;
    logic [4:0]        load_len_s;
    logic              load_ok_s;
    logic [8:0]        load_doy_s;

    leap_year_det #(.YEAR_W(YEAR_W)) u_leap_cur (
        .year (year_r),
        .leap (leap_cur_s)
    );

    leap_year_det #(.YEAR_W(YEAR_W)) u_leap_load (
        .year (load_year),
        .leap (leap_load_s)
    );

    // Month length of the current date and validation of the requested load.
    always_comb begin
        cur_len_s  = days_in_month(month_r, leap_cur_s);
        load_len_s = days_in_month(load_month, leap_load_s);
        load_ok_s  = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                     (load_day >= 5'd1) && (load_day <= load_len_s);
        load_doy_s = ordinal_day(load_day, load_month, leap_load_s);
    end

    // Date state: load has priority over tick; a rejected load also swallows the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_r       <= 5'd1;
            month_r     <= 4'd1;
            year_r      <= YEAR_W'(RESET_YEAR);
            doy_r       <= 9'd1;
            load_err_r  <= 1'b0;
            year_wrap_r <= 1'b0;
        end else begin
            load_err_r  <= 1'b0;
            year_wrap_r <= 1'b0;
            if (load) begin
                if (load_ok_s) begin
                    day_r   <= load_day;
                    month_r <= load_month;
                    year_r  <= load_year;
                    doy_r   <= load_doy_s;
                end else begin
                    load_err_r <= 1'b1;
                end
            end else if (tick) begin
                // ">=" keeps the counter self-recovering should day ever exceed the month length.
                if (day_r >= cur_len_s) begin
                    day_r <= 5'd1;
                    if (month_r >= DEC) begin
                        month_r     <= 4'd1;
                        year_r      <= year_r + YEAR_W'(1);
                        doy_r       <= 9'd1;
                        year_wrap_r <= (year_r == {YEAR_W{1'b1}});
                    end else begin
                        month_r <= month_r + 4'd1;
                        doy_r   <= doy_r + 9'd1;
                    end
                end else begin
                    day_r <= day_r + 5'd1;
                    doy_r <= doy_r + 9'd1;
                end
            end else begin
                day_r <= day_r;
            end
        end
    end

    assign day       = day_r;
    assign month     = month_r;
    assign year      = year_r;
    assign day_of_yr = doy_r;
    assign leap      = leap_cur_s;
    assign load_err  = load_err_r;
    assign year_wrap = year_wrap_r;

endmodule

// File: tb/tb_calendar_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_counter
// Directed and randomized checks of calendar_counter against a plain
// day/month/year reference model; ordinal day is recomputed from scratch by
// summing month lengths.
// -----------------------------------------------------------------------------
module tb_calendar_counter;

    localparam int YEAR_W   = 12;
    localparam int MAX_YEAR = (1 << YEAR_W);

    logic              clk;
    logic              rst;
    logic              tick;
    logic              load;
    logic [4:0]        load_day;
    logic [3:0]        load_month;
    logic [YEAR_W-1:0] load_year;
    logic [4:0]        day;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic [8:0]        day_of_yr;
    logic              leap;
    logic              load_err;
    logic              year_wrap;

    int total;
    int bad;

    // Reference model state
    int m_day, m_month, m_year;
    bit m_err, m_wrap;

    calendar_counter #(.YEAR_W(YEAR_W), .RESET_YEAR(2000)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_day   (load_day),
        .load_month (load_month),
        .load_year  (load_year),
        .day        (day),
        .month      (month),
        .year       (year),
        .day_of_yr  (day_of_yr),
        .leap       (leap),
        .load_err   (load_err),
        .year_wrap  (year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mlen(int m, int y);
        if (m == 2) return is_leap(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int ord_day(int d, int m, int y);
        int s;
        s = d;
        for (int i = 1; i < m; i++) s += mlen(i, y);
        return s;
    endfunction

    task automatic model_reset();
        m_day = 1; m_month = 1; m_year = 2000; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(bit t, bit l, int ld, int lm, int ly);
        m_err = 0; m_wrap = 0;
        if (l) begin
            if (lm >= 1 && lm <= 12 && ld >= 1 && ld <= mlen(lm, ly)) begin
                m_day = ld; m_month = lm; m_year = ly;
            end else begin
                m_err = 1;
            end
        end else if (t) begin
            m_day++;
            if (m_day > mlen(m_month, m_year)) begin
                m_day = 1;
                m_month++;
                if (m_month > 12) begin
                    m_month = 1;
                    m_year++;
                    if (m_year == MAX_YEAR) begin
                        m_year = 0;
                        m_wrap = 1;
                    end
                end
            end
        end
    endtask

    task automatic check(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".day"},       int'(day),       m_day);
        check({tag, ".month"},     int'(month),     m_month);
        check({tag, ".year"},      int'(year),      m_year);
        check({tag, ".doy"},       int'(day_of_yr), ord_day(m_day, m_month, m_year));
        check({tag, ".leap"},      int'(leap),      int'(is_leap(m_year)));
        check({tag, ".load_err"},  int'(load_err),  int'(m_err));
        check({tag, ".year_wrap"}, int'(year_wrap), int'(m_wrap));
    endtask

    // Called just after a falling edge: drive, clock, update model, check.
    task automatic step(string tag, bit t, bit l, int ld, int lm, int ly);
        tick       = t;
        load       = l;
        load_day   = 5'(ld);
        load_month = 4'(lm);
        load_year  = YEAR_W'(ly);
        @(posedge clk);
        model_step(t, l, ld, lm, ly);
        #1;
        check_all(tag);
        @(negedge clk);
        tick = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        int rt, rl, ld, lm, ly, r;
        total = 0;
        bad   = 0;
        rst = 1'b1; tick = 1'b0; load = 1'b0;
        load_day = 5'd0; load_month = 4'd0; load_year = '0;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (2) @(negedge clk);
        check_all("reset_hold");

        // First tick honoured on the first edge after release
        rst = 1'b0;
        step("first_tick", 1, 0, 0, 0, 0);

        step("ld_1900",      0, 1, 28, 2, 1900);
        step("tick_1900",    1, 0, 0, 0, 0);
        check("t1900_doy60", int'(day_of_yr), 60);

        step("ld_2000",      0, 1, 28, 2, 2000);
        step("tick_2000a",   1, 0, 0, 0, 0);
        check("t2000_doy60", int'(day_of_yr), 60);
        step("tick_2000b",   1, 0, 0, 0, 0);
        check("t2000_doy61", int'(day_of_yr), 61);

        step("ld_2023",      0, 1, 31, 12, 2023);
        check("ld2023_doy",  int'(day_of_yr), 365);
        step("tick_2024",    1, 0, 0, 0, 0);

        step("bad_ld_tick",  1, 1, 30, 2, 2024);
        check("bad_ld_err",  int'(load_err), 1);
        step("after_bad",    0, 0, 0, 0, 0);

        step("ld_4095",      0, 1, 31, 12, 4095);
        step("tick_wrap",    1, 0, 0, 0, 0);
        check("wrap_pulse",  int'(year_wrap), 1);
        step("after_wrap",   0, 0, 0, 0, 0);

        step("ld_month0",    0, 1, 5, 0, 2001);
        step("ld_month13",   0, 1, 5, 13, 2001);
        step("ld_day0",      0, 1, 0, 3, 2001);
        step("ld_feb29_nl",  0, 1, 29, 2, 2100);
        step("ld_apr31",     0, 1, 31, 4, 2001);
        step("ld_feb29_400", 0, 1, 29, 2, 2400);

        // Randomized run
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            rl = (r < 12) ? 1 : 0;
            rt = ($urandom_range(0, 99) < 75) ? 1 : 0;
            lm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
            ld = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 31);
            ly = ($urandom_range(0, 4) == 0) ? $urandom_range(MAX_YEAR - 2, MAX_YEAR - 1)
                                             : $urandom_range(0, MAX_YEAR - 1);
            if (rl == 1 && $urandom_range(0, 3) == 0) begin
                ld = $urandom_range(25, 31);
                lm = 12;
            end
            step("rand", rt[0], rl[0], ld, lm, ly);
        end

        // Asynchronous reset in the middle of a cycle
        step("pre_midrst", 0, 1, 15, 7, 1999);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        step("post_midrst", 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
